// File: rtl/seg7_scan_drv.sv
// Two-digit multiplexed 7-segment driver: per-frame digit snapshot, BCD decode,
// and a blanking gap between digit slots so the previous digit does not ghost.
module seg7_scan_drv #(
  parameter int SCAN_DIV    = 50000,
  parameter int BLANK_CYC   = 100,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit DIG_ACT_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       en,
  input  logic [3:0] digit_in [1:0],
  input  logic [1:0] dp_in,
  input  logic       lz_blank,
  output logic [6:0] seg_out,
  output logic       dp_out,
  output logic [1:0] dig_sel_out
);

  localparam int MAX_DUR = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CNT_W   = $clog2(MAX_DUR);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  localparam logic [6:0] SEG_OFF = SEG_ACT_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = SEG_ACT_LOW;
  localparam logic [1:0] DIG_OFF = DIG_ACT_LOW ? 2'b11 : 2'b00;

  // Ordering matters: the slot sequence is simply state + 1 (mod 4).
  typedef enum logic [1:0] {BLANK0 = 2'd0, SHOW0 = 2'd1, BLANK1 = 2'd2, SHOW1 = 2'd3} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       snap_q [1:0];
  logic [1:0]       snap_dp_q;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [1:0]       dig_q, dig_d;
  logic             slot_last;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    case (bcd)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= BLANK0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    slot_last = (state_q == SHOW0 || state_q == SHOW1) ? (cnt_q == SHOW_LAST)
                                                       : (cnt_q == BLANK_LAST);
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    if (!en) begin
      state_d = BLANK0;
      cnt_d   = '0;
    end else if (slot_last) begin
      state_d = state_t'(state_q + 2'd1);
      cnt_d   = '0;
    end
  end

  // Digits are frozen outside BLANK0 so a frame never mixes old and new values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      snap_q[0] <= '0;
      snap_q[1] <= '0;
      snap_dp_q <= '0;
    end else if (state_q == BLANK0) begin
      snap_q[0] <= digit_in[0];
      snap_q[1] <= digit_in[1];
      snap_dp_q <= dp_in;
    end
  end

  always_comb begin
    seg_d = SEG_OFF;
    dp_d  = DP_OFF;
    dig_d = DIG_OFF;
    if (en) begin
      case (state_q)
        SHOW0: begin
          seg_d = bcd_to_seg(snap_q[0]) ^ {7{SEG_ACT_LOW}};
          dp_d  = snap_dp_q[0] ^ SEG_ACT_LOW;
          dig_d = 2'b01 ^ {2{DIG_ACT_LOW}};
        end
        SHOW1: begin
          if (!(lz_blank && snap_q[1] == 4'd0)) begin
            seg_d = bcd_to_seg(snap_q[1]) ^ {7{SEG_ACT_LOW}};
            dp_d  = snap_dp_q[1] ^ SEG_ACT_LOW;
            dig_d = 2'b10 ^ {2{DIG_ACT_LOW}};
          end
        end
        default: ;
      endcase
    end
  end

  // Registered pins: one cycle behind the state register, glitch-free.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      seg_q <= SEG_OFF;
      dp_q  <= DP_OFF;
      dig_q <= DIG_OFF;
    end else begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
      dig_q <= dig_d;
    end
  end

  assign seg_out     = seg_q;
  assign dp_out      = dp_q;
  assign dig_sel_out = dig_q;

endmodule
